mem_issue_sched: RTL and testbench

Issue scheduler for the four-lane decode-to-execute path. It holds one decoded 4-instruction bundle, detects load/store lanes, and drives the four pair-swap controls (`ins1_swap`..`ins4_swap`) of the lane-permutation stage so that the single memory op of each issue group lands in output lane 4. Bundles with more than one memory op are split over several cycles in program order. Valid/ready handshake on both sides.

---
 rtl/mem_issue_sched.sv | 135 +++++++++++++
 tb/tb_mem_issue_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_issue_sched.sv
// Issue scheduler: splits a 4-lane bundle into groups holding at most one memory op
// and steers that op to output lane 4 through the pair-swap permutation controls.
module mem_issue_sched #(
    parameter logic [3:0] LD_OP = 4'b0100,
    parameter logic [3:0] ST_OP = 4'b0101,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bnd_vld,
    output logic             bnd_rdy,
    input  logic             in_1_vld,
    input  logic             in_2_vld,
    input  logic             in_3_vld,
    input  logic             in_4_vld,
    input  logic [3:0]       in_1_op,
    input  logic [3:0]       in_2_op,
    input  logic [3:0]       in_3_op,
    input  logic [3:0]       in_4_op,
    output logic             iss_vld,
    input  logic             iss_rdy,
    output logic             ins1_swap,
    output logic             ins2_swap,
    output logic             ins3_swap,
    output logic             ins4_swap,
    output logic [3:0]       iss_mask,
    output logic [CNT_W-1:0] split_cnt
);

    typedef enum logic {FRESH, PART} state_t;

    state_t           state_q;
    logic [3:0]       done_q, done_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

    logic [3:0] lane_vld;
    logic [3:0] lane_mem;
    logic [3:0] done_eff;
    logic [3:0] pend;
    logic [3:0] pend_mem;
    logic [3:0] grp;
    logic [1:0] m_lane;
    logic       mem_in_grp;
    logic       last_grp;
    logic       hs;
    logic [3:0] swap_raw;
    logic [3:0] mask_raw;

    function automatic logic is_mem(input logic vld, input logic [3:0] op);
        return vld && ((op == LD_OP) || (op == ST_OP));
    endfunction

    assign lane_vld = {in_4_vld, in_3_vld, in_2_vld, in_1_vld};
    assign lane_mem = {is_mem(in_4_vld, in_4_op), is_mem(in_3_vld, in_3_op),
                       is_mem(in_2_vld, in_2_op), is_mem(in_1_vld, in_1_op)};

    // done_q is only meaningful mid-split; in FRESH every valid lane is pending.
    assign done_eff = (state_q == PART) ? done_q : 4'b0000;
    assign pend     = lane_vld & ~done_eff;
    assign pend_mem = lane_mem & ~done_eff;

    // Group = pending lanes in program order up to (not including) the second memory op.
    always_comb begin
        logic seen;
        logic stop;
        grp        = 4'b0000;
        m_lane     = 2'd3;
        mem_in_grp = 1'b0;
        seen       = 1'b0;
        stop       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pend_mem[i] && seen) begin
                stop = 1'b1;
            end
            if (!stop) begin
                grp[i] = pend[i];
                if (pend_mem[i]) begin
                    seen       = 1'b1;
                    m_lane     = 2'(i);
                    mem_in_grp = 1'b1;
                end
            end
        end
    end

    // The memory lane is exchanged with lane 4; mask follows the same exchange.
    always_comb begin
        swap_raw = 4'b0000;
        mask_raw = grp;
        if (mem_in_grp && (m_lane != 2'd3)) begin
            swap_raw[m_lane] = 1'b1;
            swap_raw[3]      = 1'b1;
            mask_raw[m_lane] = grp[3];
            mask_raw[3]      = grp[m_lane];
        end
    end

    assign last_grp = (grp == pend);
    assign iss_vld  = bnd_vld & (pend != 4'b0000) & ~rst;
    assign hs       = iss_vld & iss_rdy;
    assign bnd_rdy  = bnd_vld & ~rst & ((pend == 4'b0000) | (hs & last_grp));

    assign ins1_swap = iss_vld & swap_raw[0];
    assign ins2_swap = iss_vld & swap_raw[1];
    assign ins3_swap = iss_vld & swap_raw[2];
    assign ins4_swap = iss_vld & swap_raw[3];
    assign iss_mask  = iss_vld ? mask_raw : 4'b0000;
    assign split_cnt = split_cnt_q;

    always_comb begin
        done_d      = done_eff;
        split_cnt_d = split_cnt_q;
        if (bnd_rdy) begin
            done_d = 4'b0000;
        end else if (hs) begin
            done_d = done_eff | grp;
            if (split_cnt_q != {CNT_W{1'b1}}) begin
                split_cnt_d = split_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FRESH;
            done_q      <= 4'b0000;
            split_cnt_q <= '0;
        end else begin
            done_q      <= done_d;
            split_cnt_q <= split_cnt_d;
            state_q     <= (done_d == 4'b0000) ? FRESH : PART;
        end
    end

endmodule

// File: tb/tb_mem_issue_sched.sv
// Directed bench for mem_issue_sched: swap codes, issue masks, splitting, stalls, reset, saturation.
module tb_mem_issue_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       bnd_vld;
    logic       bnd_rdy;
    logic       in_1_vld, in_2_vld, in_3_vld, in_4_vld;
    logic [3:0] in_1_op, in_2_op, in_3_op, in_4_op;
    logic       iss_vld;
    logic       iss_rdy;
    logic       ins1_swap, ins2_swap, ins3_swap, ins4_swap;
    logic [3:0] iss_mask;
    logic [7:0] split_cnt;
    logic [3:0] sw;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    mem_issue_sched #(.LD_OP(4'b0100), .ST_OP(4'b0101), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bnd_vld(bnd_vld), .bnd_rdy(bnd_rdy),
        .in_1_vld(in_1_vld), .in_2_vld(in_2_vld), .in_3_vld(in_3_vld), .in_4_vld(in_4_vld),
        .in_1_op(in_1_op), .in_2_op(in_2_op), .in_3_op(in_3_op), .in_4_op(in_4_op),
        .iss_vld(iss_vld), .iss_rdy(iss_rdy),
        .ins1_swap(ins1_swap), .ins2_swap(ins2_swap), .ins3_swap(ins3_swap), .ins4_swap(ins4_swap),
        .iss_mask(iss_mask), .split_cnt(split_cnt)
    );

    always #5 clk = ~clk;

    // Written left to right as ins1..ins4, matching the textual swap codes.
    assign sw = {ins1_swap, ins2_swap, ins3_swap, ins4_swap};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_bundle(input logic [3:0] v, input logic [3:0] o1, input logic [3:0] o2,
                              input logic [3:0] o3, input logic [3:0] o4);
        bnd_vld  = 1'b1;
        in_1_vld = v[0]; in_2_vld = v[1]; in_3_vld = v[2]; in_4_vld = v[3];
        in_1_op  = o1;   in_2_op  = o2;   in_3_op  = o3;   in_4_op  = o4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iss_rdy = 1'b1;
        set_bundle(4'b1111, 4'd0, 4'd4, 4'd5, 4'd0);
        step();
        step();
        settle();
        checks++;
        if (iss_vld !== 1'b0 || bnd_rdy !== 1'b0) begin
            $display("FAIL reset_hs: iss_vld=%b bnd_rdy=%b expected 0 0", iss_vld, bnd_rdy); errors++;
        end
        checks++;
        if (sw !== 4'b0000 || iss_mask !== 4'b0000) begin
            $display("FAIL reset_sw: swap=%b mask=%b expected 0000 0000", sw, iss_mask); errors++;
        end
        checks++;
        if (split_cnt !== 8'd0) begin
            $display("FAIL reset_cnt: split_cnt=%0d expected 0", split_cnt); errors++;
        end
        rst = 1'b0;
        bnd_vld = 1'b0;
        step();
    endtask

    task automatic test_no_mem();
        set_bundle(4'b1111, 4'd0, 4'd1, 4'd2, 4'd3);
        settle();
        checks++;
        if (iss_vld !== 1'b1 || bnd_rdy !== 1'b1 || sw !== 4'b0000 || iss_mask !== 4'b1111) begin
            $display("FAIL no_mem: vld=%b rdy=%b swap=%b mask=%b expected 1 1 0000 1111",
                     iss_vld, bnd_rdy, sw, iss_mask); errors++;
        end
        step();
        bnd_vld = 1'b0;
        settle();
        checks++;
        if (split_cnt !== 8'(exp_cnt)) begin
            $display("FAIL no_mem_cnt: split_cnt=%0d expected %0d", split_cnt, exp_cnt); errors++;
        end
    endtask

    task automatic test_ld_lane1();
        set_bundle(4'b1111, 4'd4, 4'd1, 4'd2, 4'd3);
        settle();
        checks++;
        if (bnd_rdy !== 1'b1 || sw !== 4'b1001 || iss_mask !== 4'b1111) begin
            $display("FAIL ld_lane1: rdy=%b swap=%b mask=%b expected 1 1001 1111",
                     bnd_rdy, sw, iss_mask); errors++;
        end
        step();
        bnd_vld = 1'b0;
    endtask

    task automatic test_ld_st();
        set_bundle(4'b1111, 4'd0, 4'd4, 4'd5, 4'd0);
        settle();
        checks++;
        if (bnd_rdy !== 1'b0 || sw !== 4'b0101 || iss_mask !== 4'b1001) begin
            $display("FAIL ldst_g1: rdy=%b swap=%b mask=%b expected 0 0101 1001",
                     bnd_rdy, sw, iss_mask); errors++;
        end
        step();
        settle();
        checks++;
        if (bnd_rdy !== 1'b1 || sw !== 4'b0011 || iss_mask !== 4'b1100) begin
            $display("FAIL ldst_g2: rdy=%b swap=%b mask=%b expected 1 0011 1100",
                     bnd_rdy, sw, iss_mask); errors++;
        end
        step();
        bnd_vld = 1'b0;
        exp_cnt++;
        settle();
        checks++;
        if (split_cnt !== 8'(exp_cnt)) begin
            $display("FAIL ldst_cnt: split_cnt=%0d expected %0d", split_cnt, exp_cnt); errors++;
        end
    endtask

    task automatic test_stall();
        set_bundle(4'b1111, 4'd0, 4'd4, 4'd5, 4'd0);
        iss_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (iss_vld !== 1'b1 || bnd_rdy !== 1'b0 || sw !== 4'b0101 || iss_mask !== 4'b1001) begin
                $display("FAIL stall_g1 c%0d: vld=%b rdy=%b swap=%b mask=%b expected 1 0 0101 1001",
                         c, iss_vld, bnd_rdy, sw, iss_mask); errors++;
            end
            step();
        end
        iss_rdy = 1'b1;
        step();
        iss_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (iss_vld !== 1'b1 || bnd_rdy !== 1'b0 || sw !== 4'b0011 || iss_mask !== 4'b1100) begin
                $display("FAIL stall_g2 c%0d: vld=%b rdy=%b swap=%b mask=%b expected 1 0 0011 1100",
                         c, iss_vld, bnd_rdy, sw, iss_mask); errors++;
            end
            step();
        end
        iss_rdy = 1'b1;
        settle();
        checks++;
        if (bnd_rdy !== 1'b1) begin
            $display("FAIL stall_last: bnd_rdy=%b expected 1", bnd_rdy); errors++;
        end
        step();
        bnd_vld = 1'b0;
        exp_cnt++;
        settle();
        checks++;
        if (split_cnt !== 8'(exp_cnt)) begin
            $display("FAIL stall_cnt: split_cnt=%0d expected %0d", split_cnt, exp_cnt); errors++;
        end
    endtask

    task automatic test_edge();
        logic [3:0] exp_sw [4];
        exp_sw[0] = 4'b1001; exp_sw[1] = 4'b0101; exp_sw[2] = 4'b0011; exp_sw[3] = 4'b0000;
        set_bundle(4'b0101, 4'd1, 4'd4, 4'd2, 4'd5);
        settle();
        checks++;
        if (bnd_rdy !== 1'b1 || sw !== 4'b0000 || iss_mask !== 4'b0101) begin
            $display("FAIL sparse: rdy=%b swap=%b mask=%b expected 1 0000 0101",
                     bnd_rdy, sw, iss_mask); errors++;
        end
        step();
        set_bundle(4'b0000, 4'd4, 4'd4, 4'd4, 4'd4);
        settle();
        checks++;
        if (bnd_rdy !== 1'b1 || iss_vld !== 1'b0) begin
            $display("FAIL empty: rdy=%b vld=%b expected 1 0", bnd_rdy, iss_vld); errors++;
        end
        step();
        set_bundle(4'b1111, 4'd4, 4'd4, 4'd4, 4'd4);
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++;
            if (sw !== exp_sw[c] || iss_mask !== 4'b1000 || bnd_rdy !== (c == 3)) begin
                $display("FAIL four_ld c%0d: swap=%b mask=%b rdy=%b expected %b 1000 %b",
                         c, sw, iss_mask, bnd_rdy, exp_sw[c], (c == 3)); errors++;
            end
            step();
        end
        bnd_vld = 1'b0;
        exp_cnt += 3;
        settle();
        checks++;
        if (split_cnt !== 8'(exp_cnt)) begin
            $display("FAIL four_ld_cnt: split_cnt=%0d expected %0d", split_cnt, exp_cnt); errors++;
        end
    endtask

    task automatic test_reset_mid();
        set_bundle(4'b1111, 4'd0, 4'd4, 4'd5, 4'd0);
        step();
        rst = 1'b1;
        settle();
        checks++;
        if (iss_vld !== 1'b0 || bnd_rdy !== 1'b0 || sw !== 4'b0000 || iss_mask !== 4'b0000) begin
            $display("FAIL rst_mid: vld=%b rdy=%b swap=%b mask=%b expected 0 0 0000 0000",
                     iss_vld, bnd_rdy, sw, iss_mask); errors++;
        end
        step();
        rst = 1'b0;
        exp_cnt = 0;
        settle();
        checks++;
        if (split_cnt !== 8'd0 || sw !== 4'b0101 || iss_mask !== 4'b1001) begin
            $display("FAIL rst_restart: cnt=%0d swap=%b mask=%b expected 0 0101 1001",
                     split_cnt, sw, iss_mask); errors++;
        end
        step();
        step();
        bnd_vld = 1'b0;
        exp_cnt = 1;
    endtask

    task automatic test_saturate();
        // 84 four-load bundles add 252 to the 1 carried in -> 253, then one more clips at 255.
        for (int b = 0; b < 84; b++) begin
            set_bundle(4'b1111, 4'd4, 4'd5, 4'd4, 4'd5);
            for (int c = 0; c < 4; c++) step();
        end
        bnd_vld = 1'b0;
        settle();
        checks++;
        if (split_cnt !== 8'd253) begin
            $display("FAIL sat_pre: split_cnt=%0d expected 253", split_cnt); errors++;
        end
        for (int b = 0; b < 2; b++) begin
            set_bundle(4'b1111, 4'd4, 4'd5, 4'd4, 4'd5);
            for (int c = 0; c < 4; c++) step();
            bnd_vld = 1'b0;
            settle();
            checks++;
            if (split_cnt !== 8'd255) begin
                $display("FAIL sat_hold b%0d: split_cnt=%0d expected 255", b, split_cnt); errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_mem();
        test_ld_lane1();
        test_ld_st();
        test_stall();
        test_edge();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
